// File: rtl/gcd_res_fifo.sv
// Result buffer downstream of the GCD core: in-order valid/ready FIFO of DEPTH words.
// Define GCD_RES_FIFO_BYPASS_EN to let a word flow straight through an empty buffer.
module gcd_res_fifo #(
  parameter  int WL    = 8,
  parameter  int DEPTH = 4,
  localparam int CW    = $clog2(DEPTH + 1),
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_b,
  input  logic [WL-1:0] in_res,
  input  logic          in_val,
  output logic          in_rdy,
  output logic [WL-1:0] out_res,
  output logic          out_val,
  input  logic          out_rdy,
  output logic [CW-1:0] count
);

  logic [WL-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          full, empty, byp_go, push, pop;

  always_comb begin
    full   = (cnt_q == CW'(DEPTH));
    empty  = (cnt_q == '0);
    // Readiness comes from registered occupancy only, so a pop never opens the door early.
    in_rdy = !full;
`ifdef GCD_RES_FIFO_BYPASS_EN
    byp_go  = empty && in_val && out_rdy;
    out_val = !empty || in_val;
    if (!empty)      out_res = mem_q[rd_ptr_q];
    else if (in_val) out_res = in_res;
    else             out_res = '0;
`else
    byp_go  = 1'b0;
    out_val = !empty;
    out_res = empty ? '0 : mem_q[rd_ptr_q];
`endif
    // A word that flows through the bypass is neither stored nor popped from storage.
    push = in_val && in_rdy && !byp_go;
    pop  = !empty && out_rdy;

    wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  assign count = cnt_q;

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= in_res;
  end

endmodule
